// File: rtl/ex_muldiv.sv
// Iterative signed/unsigned multiply/divide unit for the EX stage. It performs
// one shift-add or restoring-divide step per clock.
// Latency: WIDTH+2 cycles from issue to the HI/LO write. Divide-by-zero takes 2 cycles.
// Backpressure: stop_o stalls EX from the issuing cycle until the last RUN cycle.
//               annul_i aborts the operation, and no write follows.
//
// Parameters:
//   WIDTH  operand width. HI and LO are each WIDTH bits.
//   CNT_W  iteration counter width.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   op_i              000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//                     101 MADD, 110 MADDU (only with MULDIV_MADD_EN)
//   start_i, annul_i  issue strobe, flush
//   a_i, b_i          rs / rt operands
//   hi_i, lo_i        forwarded HI/LO accumulator (MADD only)
//   hi_o, lo_o        result, nonzero only in DONE
//   whilo_o           one-cycle HI/LO write enable
//   div_zero_o        divisor was zero, qualified by whilo_o
//   stop_o            pipeline stall request
// Optional feature: define MULDIV_MADD_EN to enable MADD/MADDU. When it is not
// defined, op 101/110 behave as "no operation".
module ex_muldiv #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       op_i,
   input  logic             start_i,
   input  logic             annul_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             whilo_o,
   output logic             div_zero_o,
   output logic             stop_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
`ifdef MULDIV_MADD_EN
   localparam logic [2:0] OP_MADD  = 3'b101;
   localparam logic [2:0] OP_MADDU = 3'b110;
`endif

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   logic [1:0]         r_state;
   logic [CNT_W-1:0]   r_cnt;
   // Divide: {remainder, dividend/quotient}. Multiply: {partial product, multiplier}.
   logic [2*WIDTH-1:0] r_acc;
   // Divisor for divide, multiplicand for multiply
   logic [WIDTH-1:0]   r_dvsr;
   logic               r_mul;      // latched op class: 1 = multiply family
   logic               r_neg_q;    // negate quotient / product
   logic               r_neg_r;    // negate remainder (dividend was negative)
   logic               r_div_zero;
`ifdef MULDIV_MADD_EN
   logic [2*WIDTH-1:0] r_addend;   // {hi_i,lo_i} for MADD, zero otherwise
`endif

   // ------------------------------------------------------------------
   // Issue decode
   // ------------------------------------------------------------------
   logic w_op_mul;
   logic w_op_div;
   logic w_op_signed;
   logic w_op_vld;
   logic w_start;

`ifdef MULDIV_MADD_EN
   logic w_op_madd;
   assign w_op_madd   = (op_i == OP_MADD) || (op_i == OP_MADDU);
   assign w_op_mul    = (op_i == OP_MULT) || (op_i == OP_MULTU) || w_op_madd;
   assign w_op_signed = (op_i == OP_MULT) || (op_i == OP_DIV) || (op_i == OP_MADD);
`else
   assign w_op_mul    = (op_i == OP_MULT) || (op_i == OP_MULTU);
   assign w_op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
   // Forwarded HI/LO only matters for MADD.
   logic w_unused_hilo;
   assign w_unused_hilo = ^{hi_i, lo_i};
`endif
   assign w_op_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
   // Reserved or disabled opcodes count as "none": they cause no stall and no write.
   assign w_op_vld = w_op_mul || w_op_div;
   assign w_start  = (r_state == S_IDLE) && start_i && w_op_vld && !annul_i;

   // Operand magnitudes. The core iterates on unsigned values, and the signs
   // are reapplied in DONE.
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;

   assign w_a_neg = w_op_signed && a_i[WIDTH-1];
   assign w_b_neg = w_op_signed && b_i[WIDTH-1];
   assign w_a_mag = w_a_neg ? -a_i : a_i;
   assign w_b_mag = w_b_neg ? -b_i : b_i;

   // ------------------------------------------------------------------
   // Iteration step
   // ------------------------------------------------------------------
   // Shift-add multiply: add the multiplicand into the upper half when the
   // multiplier LSB is set, then shift the whole accumulator right. The
   // carry bit becomes the new MSB.
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_next;

   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + {1'b0, (r_acc[0] ? r_dvsr : {WIDTH{1'b0}})};
   assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Restoring divide: shift the remainder left by one bit and pull in the
   // next dividend bit. Subtract the divisor when it fits. The shifted
   // remainder needs WIDTH+1 bits because the divisor may use all WIDTH bits.
   logic [WIDTH:0]     w_rem_sh;
   logic               w_ge;
   logic [WIDTH-1:0]   w_diff;
   logic [2*WIDTH-1:0] w_div_next;

   assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_ge       = (w_rem_sh >= {1'b0, r_dvsr});
   // The true difference is below 2^WIDTH whenever w_ge is set, so modulo
   // arithmetic on the low bits is exact.
   assign w_diff     = w_rem_sh[WIDTH-1:0] - r_dvsr;
   assign w_div_next = {(w_ge ? w_diff : w_rem_sh[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_ge};

   // ------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_dvsr     <= '0;
         r_mul      <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_div_zero <= 1'b0;
`ifdef MULDIV_MADD_EN
         r_addend   <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_cnt   <= '0;
                  r_mul   <= w_op_mul;
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
`ifdef MULDIV_MADD_EN
                  r_addend <= w_op_madd ? {hi_i, lo_i} : {2*WIDTH{1'b0}};
`endif
                  if (w_op_div && (b_i == {WIDTH{1'b0}})) begin
                     // The result is fixed: HI gets the raw dividend and LO gets all ones.
                     r_state    <= S_DONE;
                     r_div_zero <= 1'b1;
                     r_acc      <= {a_i, {WIDTH{1'b1}}};
                     r_dvsr     <= '0;
                  end else begin
                     r_state    <= S_RUN;
                     r_div_zero <= 1'b0;
                     if (w_op_mul) begin
                        r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
                        r_dvsr <= w_a_mag;
                     end else begin
                        r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_dvsr <= w_b_mag;
                     end
                  end
               end
            end
            S_RUN: begin
               if (annul_i) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_acc <= r_mul ? w_mul_next : w_div_next;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == LAST_CNT) begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               // The instruction that issued this op is still presented here,
               // so start_i is ignored. Always return to IDLE.
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Result fix-up and outputs
   // ------------------------------------------------------------------
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_mul_res;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic [2*WIDTH-1:0] w_res;
   logic               w_done;
   logic               w_wr;

   assign w_prod = r_neg_q ? -r_acc : r_acc;
`ifdef MULDIV_MADD_EN
   assign w_mul_res = w_prod + r_addend;
`else
   assign w_mul_res = w_prod;
`endif
   // For most-negative / -1, the magnitude quotient 2^(WIDTH-1) is not
   // negated, and it reads back as most-negative. No special case is needed.
   assign w_quo = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   always_comb begin
      w_res = {w_rem, w_quo};
      if (r_div_zero) begin
         w_res = r_acc;
      end else if (r_mul) begin
         w_res = w_mul_res;
      end
   end

   assign w_done = (r_state == S_DONE);
   assign w_wr   = w_done && !annul_i;

   // Outputs stay zero outside DONE, so EX can OR them with its other HI/LO sources.
   assign hi_o       = w_done ? w_res[2*WIDTH-1:WIDTH] : {WIDTH{1'b0}};
   assign lo_o       = w_done ? w_res[WIDTH-1:0]       : {WIDTH{1'b0}};
   assign whilo_o    = w_wr;
   assign div_zero_o = w_wr && r_div_zero;
   assign stop_o     = w_start || (r_state == S_RUN);

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Multi-cycle multiply/divide unit for the EX stage; successor to the fixed 32-bit divider.
- Parametrised data width; iterative, 1 bit per cycle.
- Covers signed and unsigned MULT and DIV; can abort an in-flight operation.
- Drives the HI/LO write triple and the pipeline stall request that EX merges into its own outputs.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low; rst=0 forces reset immediately.
- op_i  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MADD, 110 MADDU.
- start_i  in  1  op_i valid and EX instruction present.
- annul_i  in  1  flush; abort current operation.
- a_i  in  WIDTH  rs operand (dividend / multiplicand).
- b_i  in  WIDTH  rt operand (divisor / multiplier).
- hi_i  in  WIDTH  forwarded HI, used by MADD only.
- lo_i  in  WIDTH  forwarded LO, used by MADD only.
- hi_o  out  WIDTH  HI result (remainder / product high).
- lo_o  out  WIDTH  LO result (quotient / product low).
- whilo_o  out  1  HI/LO write enable, one cycle.
- div_zero_o  out  1  divisor was zero; valid with whilo_o.
- stop_o  out  1  stall request to pipeline control.

Behaviour:
- States: IDLE, RUN, DONE. Registers: state, counter, accumulator (2*WIDTH), divisor/multiplicand (WIDTH), sign flags, latched op.
- Reset (rst=0, any state, mid-op included): state=IDLE, counter=0, all datapath registers 0. Outputs in IDLE: hi_o=0, lo_o=0, whilo_o=0, div_zero_o=0.
- IDLE:
  - start_i=1 with op_i≠000 and annul_i=0: latch operands as magnitudes for signed ops, record result signs, go to RUN, counter=0.
  - DIV/DIVU with b_i==0: go straight to DONE with div_zero flag set.
  - Otherwise stay in IDLE.
- RUN:
  - One restoring-division or shift-add step per cycle; counter increments.
  - When counter==WIDTH-1, go to DONE.
- DONE:
  - whilo_o=1, hi_o/lo_o hold the final result, stop_o=0.
  - Next cycle unconditionally IDLE; start_i is ignored in DONE (the same instruction is still presented).
- stop_o = (state==IDLE & start_i & op_i≠000 & ~annul_i) | (state==RUN). Combinational, so the issuing cycle stalls.
- EX holds op_i, a_i, b_i stable while stop_o=1. The unit uses latched copies, so instability is harmless.
- Latency: start cycle T0, RUN T1..T_WIDTH, DONE at T_WIDTH+1. WIDTH+2 cycles total. Divide-by-zero: DONE at T1.
- Division results:
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Signed: quotient negated when operand signs differ.
  - Most-negative / -1: quotient = most-negative, remainder 0. No trap.
- Divide by zero: lo_o = all ones, hi_o = a_i (as latched), div_zero_o=1.
- Multiply: {hi_o,lo_o} = full 2*WIDTH product. Signed: product negated when signs differ.
- annul_i=1 in RUN or DONE: next state IDLE, whilo_o forced 0 the same cycle, stop_o=0.
- annul_i and start_i both 1 in IDLE: annul wins; no start.
- Outside DONE, hi_o/lo_o/whilo_o/div_zero_o are 0, so EX may OR them with the other HI/LO sources.

Optional Feature:
- Macro MULDIV_MADD_EN.
- Defined:
  - op 101/110 perform MADD/MADDU: {hi_o,lo_o} = {hi_i,lo_i} + product, modulo 2^(2*WIDTH).
  - hi_i/lo_i are latched at start; same latency as MULT.
- Undefined:
  - op 101/110 are treated as 000: no stall, no write.
  - hi_i/lo_i are unused.

Test Plan:
- WIDTH=32, DIVU a=7, b=2 -> stop_o high 33 cycles, then 1 cycle whilo_o=1, lo_o=3, hi_o=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- DIVU a=5, b=0 -> DONE one cycle after start:
  - lo_o=0xFFFFFFFF, hi_o=5, div_zero_o=1, total stall 1 cycle.
- MULT a=0xFFFFFFFF, b=2 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE.
- MULTU same operands -> hi_o=1, lo_o=0xFFFFFFFE.
- DIVU started, then abort mid-op:
  - annul_i=1 at cycle 10 -> stop_o=0 next cycle, no whilo_o pulse.
  - rst=0 at cycle 12 of a new DIV -> immediate IDLE with outputs 0.
- MULDIV_MADD_EN defined: MADDU hi_i=0, lo_i=0xFFFFFFFF, a=1, b=1 -> hi_o=1, lo_o=0.
- MULDIV_MADD_EN undefined: same op -> stop_o=0 and no write.
